spi_slave_byte_if: RTL and testbench
====================================

// Module: spi_slave_byte_if
// PURPOSE
//  SPI responder (slave) side of the AHBspi link, for peripherals hung off the AHBspi master (e.g. display, sensors).
//  Oversamples SCLK/SS/MOSI on the local block clock, shifts in MOSI bytes, shifts out MISO bytes.
//  Presents a byte-wide valid/ready TX port and a valid/ack RX port to local logic.
//  SPI mode 0 (CPOL=0, CPHA=0), MSB first, SS active low.
// PARAMETERS
//  DATA_WIDTH    8      bits per SPI word
//  SYNC_STAGES   2      flip-flop stages on each SPI input (>=2)
//  UNDERRUN_WORD 8'h00  word shifted out when no TX word is held at a word boundary
// PORTS
//  block_clk_i   in   1           local clock; all logic on rising edge
//  rst_i         in   1           synchronous reset, active high
//  spi_sclk_i    in   1           SPI clock from master, idle low
//  spi_ss_i      in   1           slave select, active low
//  spi_mosi_i    in   1           master-out data
//  spi_miso_o    out  1           slave-out data; 0 when not selected
//  tx_data_i     in   DATA_WIDTH  next word to send
//  tx_valid_i    in   1           tx_data_i valid
//  tx_ready_o    out  1           holding register empty; word accepted when valid&ready
//  rx_data_o     out  DATA_WIDTH  last complete received word
//  rx_valid_o    out  1           rx_data_o unread; level, cleared by rx_ack_i
//  rx_ack_i      in   1           local logic consumed rx_data_o
//  rx_overrun_o  out  1           1-cycle pulse: new word arrived while rx_valid_o high
//  tx_underrun_o out  1           1-cycle pulse: UNDERRUN_WORD loaded (holding empty)
//  busy_o        out  1           high in ACTIVE state
// BEHAVIOUR
//  Reset: miso 0, tx_ready 1, rx_data 0, rx_valid 0, pulses 0, busy 0, bit_cnt 0, shift regs 0, state RESYNC.
//  Inputs pass SYNC_STAGES FFs; edges detected from last stage vs one extra delayed copy.
//  Edge-to-action latency SYNC_STAGES+1 block_clk cycles; SCLK half-period >= SYNC_STAGES+1 block_clk cycles.
//  States:
//   RESYNC: ignore SPI; -> IDLE when synced SS high. (Reset mid-frame never joins a frame in progress.)
//   IDLE:   on synced SS falling edge -> ACTIVE; bit_cnt=0; load tx shift reg (see TX load).
//   ACTIVE: SS rising edge -> IDLE; partial RX word discarded, bit_cnt=0, no rx_valid.
//  TX load: if holding full, shift <= holding, holding emptied (tx_ready 1 next cycle);
//   else shift <= UNDERRUN_WORD and tx_underrun_o pulses.
//  Holding write on tx_valid&tx_ready same cycle as a load: load sees empty (underrun),
//   new word goes to holding.
//  SCLK rising (ACTIVE): rx_shift <= {rx_shift[W-2:0], mosi}; bit_cnt++ mod W.
//   On bit W-1: rx_data_o <= full word; rx_valid_o=1 next cycle; bit_cnt=0;
//   if rx_valid_o already 1 and no rx_ack_i that cycle, rx_overrun_o pulses (new word overwrites).
//   rx_ack_i same cycle as word completion: new word wins, rx_valid stays 1, no overrun.
//  SCLK falling (ACTIVE): bit_cnt==0 -> TX load; else tx shift left 1.
//  spi_miso_o = tx_shift[W-1] when ACTIVE, else 0. Registered, changes only after falling edge or load.
//  rx_ack_i with rx_valid 0: no effect. Ack-only cycle clears rx_valid next cycle.
//  Multi-word frames: bit_cnt wraps W-1 -> 0 without SS toggle; words back-to-back.
//  SCLK edges while IDLE/RESYNC ignored.
// TESTING
//  1 Hold rst_i 2 cycles, SS high -> all outputs at reset values, busy 0, tx_ready 1.
//  2 Push tx 0xA5; frame of 8 SCLK, MOSI=0x3C -> MISO 1,0,1,0,0,1,0,1 at rising edges;
//    rx_data 0x3C, rx_valid 1; tx_underrun never pulses.
//  3 Push only 0x81; 16-SCLK frame MOSI 0x11,0x08 -> MISO 0x81 then 0x00,
//    one tx_underrun pulse; rx 0x11 then 0x08 with rx_overrun pulse (no ack).
//  4 Same as 3 but rx_ack_i after first word -> no overrun, rx_data 0x08 valid at end.
//  5 SS high after 5 SCLK -> no rx_valid, busy 0; next 8-bit frame MOSI 0xC3 -> rx_data 0xC3.
//  6 rst_i mid-frame with SS low, SCLK running -> no rx_valid until SS high then low;
//    following frame MOSI 0x5A received correctly.

Source files
------------

// File: rtl/spi_slave_byte_if_if.sv
// Byte-wide local port of the SPI responder: TX valid/ready, RX valid/ack and status.
// The slave modport is the responder's view; the master modport is the local logic's view.
interface spi_slave_byte_if_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data_i;
   logic                  tx_valid_i;
   logic                  tx_ready_o;
   logic [DATA_WIDTH-1:0] rx_data_o;
   logic                  rx_valid_o;
   logic                  rx_ack_i;
   logic                  rx_overrun_o;
   logic                  tx_underrun_o;
   logic                  busy_o;

   modport slave (
      input  tx_data_i, tx_valid_i, rx_ack_i,
      output tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o, tx_underrun_o, busy_o
   );

   modport master (
      output tx_data_i, tx_valid_i, rx_ack_i,
      input  tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o, tx_underrun_o, busy_o
   );
endinterface

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 responder, MSB first, oversampled on block_clk_i; one TX holding register
// and a single-word RX output with overrun/underrun status pulses.
module spi_slave_byte_if #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    SYNC_STAGES   = 2,
   parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = '0
) (
   input  logic                block_clk_i,
   input  logic                rst_i,
   input  logic                spi_sclk_i,
   input  logic                spi_ss_i,
   input  logic                spi_mosi_i,
   output logic                spi_miso_o,
   spi_slave_byte_if_if.slave  byte_if
);
   localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_ACTIVE} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_d_q, ss_d_q;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

   logic                  tx_load, tx_shift_en, rx_shift_en, frame_abort;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, hold_q, rx_data_q;
   logic                  hold_full_q, rx_valid_q, rx_overrun_q, tx_underrun_q, miso_q;
   logic                  hold_wr;

   // Synchronisers reset to 0 so a low SS seen right after reset reads as "inside a
   // frame" and RESYNC waits for a genuine SS high instead of joining mid-frame.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge block_clk_i) begin
      if (rst_i) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_d_q    <= 1'b0;
         ss_d_q      <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
         sclk_d_q    <= sclk_sync_q[SYNC_STAGES-1];
         ss_d_q      <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_q;
   assign sclk_fall = ~sclk_s & sclk_d_q;
   assign ss_rise   = ss_s & ~ss_d_q;
   assign ss_fall   = ~ss_s & ss_d_q;

   always_ff @(posedge block_clk_i) begin
      if (rst_i) state_q <= ST_RESYNC;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      tx_load     = 1'b0;
      tx_shift_en = 1'b0;
      rx_shift_en = 1'b0;
      frame_abort = 1'b0;
      case (state_q)
         ST_RESYNC: if (ss_s) state_d = ST_IDLE;
         ST_IDLE: begin
            if (ss_fall) begin
               state_d = ST_ACTIVE;
               tx_load = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               state_d     = ST_IDLE;
               frame_abort = 1'b1;
            end else begin
               rx_shift_en = sclk_rise;
               if (sclk_fall) begin
                  if (bit_cnt_q == '0) tx_load     = 1'b1;
                  else                 tx_shift_en = 1'b1;
               end
            end
         end
         default: state_d = ST_RESYNC;
      endcase
   end

   assign hold_wr = byte_if.tx_valid_i & ~hold_full_q;

   always_ff @(posedge block_clk_i) begin
      if (rst_i) begin
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
         miso_q        <= 1'b0;
      end else begin
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;

         if (byte_if.rx_ack_i) rx_valid_q <= 1'b0;

         if (frame_abort) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
         end

         // A completing word overrides a same-cycle ack: the new word stays valid.
         if (rx_shift_en) begin
            rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_q    <= '0;
               rx_data_q    <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
               rx_valid_q   <= 1'b1;
               rx_overrun_q <= rx_valid_q & ~byte_if.rx_ack_i;
            end else begin
               bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
         end

         if (tx_load) begin
            if (hold_full_q) begin
               tx_shift_q  <= hold_q;
               miso_q      <= hold_q[DATA_WIDTH-1];
               hold_full_q <= 1'b0;
            end else begin
               tx_shift_q    <= UNDERRUN_WORD;
               miso_q        <= UNDERRUN_WORD[DATA_WIDTH-1];
               tx_underrun_q <= 1'b1;
            end
         end

         if (tx_shift_en) begin
            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_q     <= tx_shift_q[DATA_WIDTH-2];
         end

         // Written after the load so a same-cycle write refills the just-checked holding slot.
         if (hold_wr) begin
            hold_q      <= byte_if.tx_data_i;
            hold_full_q <= 1'b1;
         end
      end
   end

   assign spi_miso_o            = miso_q;
   assign byte_if.tx_ready_o    = ~hold_full_q;
   assign byte_if.rx_data_o     = rx_data_q;
   assign byte_if.rx_valid_o    = rx_valid_q;
   assign byte_if.rx_overrun_o  = rx_overrun_q;
   assign byte_if.tx_underrun_o = tx_underrun_q;
   assign byte_if.busy_o        = (state_q == ST_ACTIVE);
endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Scoreboarded bench for spi_slave_byte_if: directed mode-0 frames plus random frames,
// compared against a word-level model of holding register, underruns and RX overruns.
module tb_spi_slave_byte_if;
   localparam int          W     = 8;
   localparam int          SYNC  = 2;
   localparam int          HALF  = 4;
   localparam logic [7:0]  UNDER = 8'h00;

   logic block_clk = 1'b0;
   logic rst       = 1'b1;
   logic sclk      = 1'b0;
   logic ss        = 1'b1;
   logic mosi      = 1'b0;
   logic miso;

   spi_slave_byte_if_if #(.DATA_WIDTH(W)) bif ();

   spi_slave_byte_if #(
      .DATA_WIDTH(W), .SYNC_STAGES(SYNC), .UNDERRUN_WORD(UNDER)
   ) dut (
      .block_clk_i(block_clk),
      .rst_i      (rst),
      .spi_sclk_i (sclk),
      .spi_ss_i   (ss),
      .spi_mosi_i (mosi),
      .spi_miso_o (miso),
      .byte_if    (bif)
   );

   always #5 block_clk = ~block_clk;

   typedef struct {
      logic [7:0] data;
      logic       ovr;
   } rx_exp_t;

   int         errors = 0;
   int         checks = 0;
   rx_exp_t    rx_q[$];
   int         acks_left = 0;
   bit         ack_stale = 0;
   int         underrun_seen = 0;
   bit         model_valid = 0;
   logic [7:0] model_last = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: detects each newly presented RX word, pops the scoreboard and acks on request.
   initial begin : monitor
      bit      prev_valid;
      rx_exp_t e;
      prev_valid    = 1'b0;
      bif.rx_ack_i  = 1'b0;
      forever begin
         @(negedge block_clk);
         bif.rx_ack_i = 1'b0;
         if (bif.tx_underrun_o) underrun_seen++;
         if ((bif.rx_valid_o && !prev_valid) || bif.rx_overrun_o) begin
            if (rx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected: got word 0x%0h, no word expected", bif.rx_data_o);
            end else begin
               e = rx_q.pop_front();
               check("rx_data", bif.rx_data_o, e.data);
               check("rx_overrun", bif.rx_overrun_o, e.ovr);
            end
            if (acks_left > 0) begin
               acks_left--;
               bif.rx_ack_i = 1'b1;
            end
         end else if (ack_stale && bif.rx_valid_o) begin
            ack_stale    = 1'b0;
            bif.rx_ack_i = 1'b1;
         end
         prev_valid = bif.rx_valid_o;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge block_clk);
   endtask

   task automatic push_tx(input logic [7:0] word);
      int budget;
      budget = 20;
      while (!bif.tx_ready_o && budget > 0) begin
         @(negedge block_clk);
         budget--;
      end
      check("tx_ready_wait", bif.tx_ready_o, 1'b1);
      bif.tx_data_i  = word;
      bif.tx_valid_i = 1'b1;
      @(negedge block_clk);
      bif.tx_valid_i = 1'b0;
      check("tx_ready_after_push", bif.tx_ready_o, 1'b0);
   endtask

   // Ack a leftover word so the next frame starts from an empty RX output.
   task automatic drain_rx();
      if (model_valid) begin
         ack_stale = 1'b1;
         wait_cycles(4);
         model_valid = 1'b0;
      end
      check("rx_valid_drained", bif.rx_valid_o, 1'b0);
   endtask

   // Mode-0 master: data set while SCLK low, MISO read just before each rising edge;
   // the final SCLK fall coincides with SS release so no trailing word load occurs.
   task automatic spi_xfer(input int nbits, input logic [23:0] mosi_vec, output logic [23:0] miso_vec);
      miso_vec = '0;
      ss = 1'b0;
      wait_cycles(HALF);
      check("busy_in_frame", bif.busy_o, 1'b1);
      for (int b = 0; b < nbits; b++) begin
         mosi = mosi_vec[23-b];
         wait_cycles(HALF);
         miso_vec[23-b] = miso;
         sclk = 1'b1;
         wait_cycles(HALF);
         sclk = 1'b0;
         if (b == nbits - 1) ss = 1'b1;
      end
      mosi = 1'b0;
      wait_cycles(2 * HALF);
   endtask

   task automatic do_frame(input bit pushed, input logic [7:0] push_word, input int nwords,
                           input logic [23:0] mosi_vec, input int acks);
      logic [23:0] exp_miso, got;
      logic [7:0]  txw, rxw;
      int          exp_under, u0;
      exp_miso  = '0;
      exp_under = 0;
      if (pushed) push_tx(push_word);
      for (int i = 0; i < nwords; i++) begin
         if (i == 0 && pushed) txw = push_word;
         else begin
            txw = UNDER;
            exp_under++;
         end
         exp_miso[23-8*i -: 8] = txw;
         rxw = mosi_vec[23-8*i -: 8];
         rx_q.push_back('{data: rxw, ovr: model_valid});
         model_valid = 1'b1;
         if (i < acks) model_valid = 1'b0;
         model_last = rxw;
      end
      acks_left = acks;
      u0 = underrun_seen;
      spi_xfer(8 * nwords, mosi_vec, got);
      for (int i = 0; i < nwords; i++)
         check($sformatf("miso_word%0d", i), got[23-8*i -: 8], exp_miso[23-8*i -: 8]);
      check("busy_after_frame", bif.busy_o, 1'b0);
      check("miso_idle", miso, 1'b0);
      check("rx_words_pending", rx_q.size(), 0);
      check("underrun_count", underrun_seen - u0, exp_under);
      check("rx_valid_end", bif.rx_valid_o, model_valid);
      if (model_valid) check("rx_data_end", bif.rx_data_o, model_last);
      check("tx_ready_end", bif.tx_ready_o, 1'b1);
   endtask

   initial begin : stimulus
      logic [23:0] got;
      int          u0;
      bit          pushed;
      int          nwords, acks;
      logic [7:0]  word;

      bif.tx_data_i  = '0;
      bif.tx_valid_i = 1'b0;

      // Reset with SS high
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      @(negedge block_clk);
      check("rst_miso", miso, 1'b0);
      check("rst_tx_ready", bif.tx_ready_o, 1'b1);
      check("rst_rx_data", bif.rx_data_o, 8'h00);
      check("rst_rx_valid", bif.rx_valid_o, 1'b0);
      check("rst_overrun", bif.rx_overrun_o, 1'b0);
      check("rst_underrun", bif.tx_underrun_o, 1'b0);
      check("rst_busy", bif.busy_o, 1'b0);
      wait_cycles(6);

      // Single word with a held TX word
      do_frame(1'b1, 8'hA5, 1, {8'h3C, 16'h0}, 0);
      drain_rx();

      // Two words, one held TX word, no ack -> underrun and overrun
      do_frame(1'b1, 8'h81, 2, {8'h11, 8'h08, 8'h00}, 0);
      drain_rx();

      // Same with the first word acked
      do_frame(1'b1, 8'h81, 2, {8'h11, 8'h08, 8'h00}, 1);
      drain_rx();

      // Aborted partial word, then a clean frame
      u0 = underrun_seen;
      spi_xfer(5, {8'hE8, 16'h0}, got);
      check("partial_busy", bif.busy_o, 1'b0);
      check("partial_rx_valid", bif.rx_valid_o, 1'b0);
      check("partial_underrun", underrun_seen - u0, 1);
      do_frame(1'b0, 8'h00, 1, {8'hC3, 16'h0}, 0);
      drain_rx();

      // Reset in the middle of a frame with SCLK running
      push_tx(8'h77);
      u0 = underrun_seen;
      ss = 1'b0;
      wait_cycles(HALF);
      for (int b = 0; b < 8; b++) begin
         if (b == 3) begin
            rst = 1'b1;
            wait_cycles(2);
            rst = 1'b0;
            model_valid = 1'b0;
         end
         mosi = 1'($urandom_range(0, 1));
         wait_cycles(HALF);
         sclk = 1'b1;
         wait_cycles(HALF);
         sclk = 1'b0;
         if (b == 5) check("rstmid_busy", bif.busy_o, 1'b0);
      end
      ss = 1'b1;
      mosi = 1'b0;
      wait_cycles(2 * HALF);
      check("rstmid_rx_valid", bif.rx_valid_o, 1'b0);
      check("rstmid_tx_ready", bif.tx_ready_o, 1'b1);
      check("rstmid_underrun", underrun_seen - u0, 0);
      do_frame(1'b0, 8'h00, 1, {8'h5A, 16'h0}, 0);

      // Random frames: optional held word, 1-3 words, random ack count
      for (int f = 0; f < 16; f++) begin
         pushed = bit'($urandom_range(0, 1));
         word   = 8'($urandom);
         nwords = $urandom_range(1, 3);
         acks   = $urandom_range(0, nwords);
         do_frame(pushed, word, nwords, 24'($urandom), acks);
         wait_cycles($urandom_range(0, 5));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
